// File: rtl/core_pkg.sv
// Shared types for the operand-fetch stage.
package core_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int CTRL_W     = 32;
  localparam int PC_W       = 32;
  localparam int NUM_SRC    = 2;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  // S1 slot: instruction whose regfile read is in flight (or stalled).
  // fwdN=1 means dN is authoritative and rf data must be ignored.
  typedef struct packed {
    logic              valid;
    reg_addr_t         rs0;
    reg_addr_t         rs1;
    reg_addr_t         rd;
    logic [PC_W-1:0]   pc;
    logic [CTRL_W-1:0] ctrl;
    logic              fwd0;
    logic              fwd1;
    xlen_t             d0;
    xlen_t             d1;
  } opf_slot_t;

endpackage

// File: rtl/core_opf_fwd.sv
// Per-operand select: x0 -> 0, live writeback hit, stored forward, regfile data.
module core_opf_fwd
  import core_pkg::*;
(
  input  reg_addr_t rs,
  input  logic      wb_we,
  input  reg_addr_t wb_addr,
  input  xlen_t     wb_data,
  input  logic      fwd,
  input  xlen_t     fwd_data,
  input  xlen_t     rf_data,
  output xlen_t     op
);

  // Priority: x0 never forwarded, the newest writeback beats anything stored.
  always_comb begin
    op = rf_data;
    if (rs == '0)                     op = '0;
    else if (wb_we && wb_addr == rs)  op = wb_data;
    else if (fwd)                     op = fwd_data;
  end

endmodule

// File: rtl/core_operand_fetch.sv
// Operand fetch: S1 waits on the registered regfile read, EX presents operands.
module core_operand_fetch
  import core_pkg::*;
#(
  parameter int CTRL_W = core_pkg::CTRL_W,
  parameter int XLEN   = core_pkg::XLEN
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  output logic              id_ready_o,
  input  logic [4:0]        id_rs0_addr_i,
  input  logic [4:0]        id_rs1_addr_i,
  input  logic [4:0]        id_rd_addr_i,
  input  logic [31:0]       id_pc_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  output logic [4:0]        rf_rs0_addr_o,
  output logic [4:0]        rf_rs1_addr_o,
  input  logic [XLEN-1:0]   rf_rs0_data_i,
  input  logic [XLEN-1:0]   rf_rs1_data_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [XLEN-1:0]   wb_data_i,
  output logic              ex_valid_o,
  input  logic              ex_ready_i,
  output logic [XLEN-1:0]   ex_rs0_data_o,
  output logic [XLEN-1:0]   ex_rs1_data_o,
  output logic [4:0]        ex_rd_addr_o,
  output logic [31:0]       ex_pc_o,
  output logic [CTRL_W-1:0] ex_ctrl_o
);

  opf_slot_t s1;

  logic              ex_valid;
  reg_addr_t         ex_rs0, ex_rs1, ex_rd;
  logic [31:0]       ex_pc;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [NUM_SRC-1:0][XLEN-1:0] ex_d;

  logic s1_move, accept;

  logic [NUM_SRC-1:0][REG_ADDR_W-1:0] id_rs, s1_rs, ex_rs;
  logic [NUM_SRC-1:0][XLEN-1:0]       s1_d, rf_d, src_op;
  logic [NUM_SRC-1:0]                 s1_fwd, id_hit, ex_hit;

  assign s1_move    = s1.valid && (!ex_valid || ex_ready_i);
  assign id_ready_o = !flush_i && (!s1.valid || !ex_valid || ex_ready_i);
  assign accept     = id_valid_i && id_ready_o;

  assign rf_rs0_addr_o = id_rs0_addr_i;
  assign rf_rs1_addr_o = id_rs1_addr_i;

  assign id_rs  = {id_rs1_addr_i, id_rs0_addr_i};
  assign s1_rs  = {s1.rs1, s1.rs0};
  assign ex_rs  = {ex_rs1, ex_rs0};
  assign s1_d   = {s1.d1, s1.d0};
  assign s1_fwd = {s1.fwd1, s1.fwd0};
  assign rf_d   = {rf_rs1_data_i, rf_rs0_data_i};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    // Capture-time hit: regfile read this cycle returns the pre-write value.
    assign id_hit[g] = wb_we_i && (wb_addr_i == id_rs[g]) && (id_rs[g] != '0);
    // Snoop for an operand parked in EX.
    assign ex_hit[g] = wb_we_i && (wb_addr_i == ex_rs[g]) && (ex_rs[g] != '0);

    core_opf_fwd u_fwd (
      .rs       (s1_rs[g]),
      .wb_we    (wb_we_i),
      .wb_addr  (wb_addr_i),
      .wb_data  (wb_data_i),
      .fwd      (s1_fwd[g]),
      .fwd_data (s1_d[g]),
      .rf_data  (rf_d[g]),
      .op       (src_op[g])
    );
  end

  // S1: capture on accept; while stalled, latch the resolved operand every
  // cycle so rf data (valid only on the first cycle) and later wb hits stick.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      s1 <= '0;
    end else if (accept) begin
      s1.valid <= 1'b1;
      s1.rs0   <= id_rs0_addr_i;
      s1.rs1   <= id_rs1_addr_i;
      s1.rd    <= id_rd_addr_i;
      s1.pc    <= id_pc_i;
      s1.ctrl  <= id_ctrl_i;
      s1.fwd0  <= id_hit[0];
      s1.fwd1  <= id_hit[1];
      s1.d0    <= wb_data_i;
      s1.d1    <= wb_data_i;
    end else if (s1_move) begin
      s1.valid <= 1'b0;
    end else if (s1.valid) begin
      s1.fwd0 <= 1'b1;
      s1.fwd1 <= 1'b1;
      s1.d0   <= src_op[0];
      s1.d1   <= src_op[1];
    end
  end

  // EX: load from S1, hold under backpressure while snooping wb, else drain.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      ex_valid <= 1'b0;
      ex_rs0   <= '0;
      ex_rs1   <= '0;
      ex_rd    <= '0;
      ex_pc    <= '0;
      ex_ctrl  <= '0;
      ex_d     <= '0;
    end else if (s1_move) begin
      ex_valid <= 1'b1;
      ex_rs0   <= s1.rs0;
      ex_rs1   <= s1.rs1;
      ex_rd    <= s1.rd;
      ex_pc    <= s1.pc;
      ex_ctrl  <= s1.ctrl;
      ex_d     <= src_op;
    end else if (ex_valid && !ex_ready_i) begin
      for (int i = 0; i < NUM_SRC; i++)
        if (ex_hit[i]) ex_d[i] <= wb_data_i;
    end else if (ex_valid) begin
      ex_valid <= 1'b0;
    end
  end

  assign ex_valid_o    = ex_valid;
  assign ex_rs0_data_o = ex_d[0];
  assign ex_rs1_data_o = ex_d[1];
  assign ex_rd_addr_o  = ex_rd;
  assign ex_pc_o       = ex_pc;
  assign ex_ctrl_o     = ex_ctrl;

endmodule

// File: tb/tb_core_operand_fetch.sv
// Directed bench for core_operand_fetch with a registered read-before-write regfile.
module tb_core_operand_fetch;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic        id_valid, id_ready;
  logic [4:0]  id_rs0, id_rs1, id_rd;
  logic [31:0] id_pc, id_ctrl;
  logic [4:0]  rf_a0, rf_a1;
  logic [31:0] rf_d0, rf_d1;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_d0, ex_d1, ex_pc, ex_ctrl;
  logic [4:0]  ex_rd;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  core_operand_fetch dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .id_valid_i(id_valid), .id_ready_o(id_ready),
    .id_rs0_addr_i(id_rs0), .id_rs1_addr_i(id_rs1), .id_rd_addr_i(id_rd),
    .id_pc_i(id_pc), .id_ctrl_i(id_ctrl),
    .rf_rs0_addr_o(rf_a0), .rf_rs1_addr_o(rf_a1),
    .rf_rs0_data_i(rf_d0), .rf_rs1_data_i(rf_d1),
    .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready),
    .ex_rs0_data_o(ex_d0), .ex_rs1_data_o(ex_d1),
    .ex_rd_addr_o(ex_rd), .ex_pc_o(ex_pc), .ex_ctrl_o(ex_ctrl)
  );

  // Regfile model: registered read returns the value before a same-edge write.
  logic [31:0] regs [32];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= (i == 0) ? 32'h0 : 32'hA000_0000 + i;
    end else if (wb_we && wb_addr != 5'd0) begin
      regs[wb_addr] <= wb_data;
    end
    rf_d0 <= (rf_a0 == 5'd0) ? 32'h0 : regs[rf_a0];
    rf_d1 <= (rf_a1 == 5'd0) ? 32'h0 : regs[rf_a1];
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, got, exp);
  endtask

  task automatic issue(input logic [4:0] r0, input logic [4:0] r1, input logic [4:0] rd,
                       input logic [31:0] pc, input logic [31:0] ctrl);
    id_valid = 1'b1; id_rs0 = r0; id_rs1 = r1; id_rd = rd; id_pc = pc; id_ctrl = ctrl;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    wb_we = 1'b1; wb_addr = a; wb_data = d;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; id_valid = 1'b0; id_rs0 = '0; id_rs1 = '0; id_rd = '0;
    id_pc = '0; id_ctrl = '0; wb_we = 1'b0; wb_addr = '0; wb_data = '0; ex_ready = 1'b1;
    tick; tick;
    chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_ex_rs0", ex_d0, 32'h0);
    chk("rst_ex_pc", ex_pc, 32'h0);
    rst = 1'b0;
    settle;
    chk("idle_id_ready", {31'b0, id_ready}, 32'd1);

    // x5 written well before use; rs1=x0.
    wb(5'd5, 32'h1234); tick; wb_we = 1'b0;
    issue(5'd5, 5'd0, 5'd9, 32'h100, 32'hC0DE); tick;
    id_valid = 1'b0;
    chk("lat_t1_ex_valid", {31'b0, ex_valid}, 32'd0);
    tick;
    chk("lat_t2_ex_valid", {31'b0, ex_valid}, 32'd1);
    chk("basic_rs0", ex_d0, 32'h0000_1234);
    chk("basic_rs1", ex_d1, 32'h0);
    chk("basic_rd", {27'b0, ex_rd}, 32'd9);
    chk("basic_pc", ex_pc, 32'h100);
    chk("basic_ctrl", ex_ctrl, 32'hC0DE);

    // wb x7 in the accept cycle.
    issue(5'd7, 5'd5, 5'd1, 32'h110, 32'h1); wb(5'd7, 32'hAAAA); tick;
    id_valid = 1'b0; wb_we = 1'b0; tick;
    chk("fwd_t_rs0", ex_d0, 32'hAAAA);
    chk("fwd_t_rs1", ex_d1, 32'h1234);

    // AAAA in T, BBBB in T+1: newest wins, both sources the same register.
    issue(5'd7, 5'd7, 5'd2, 32'h120, 32'h2); wb(5'd7, 32'hAAAA); tick;
    id_valid = 1'b0; wb(5'd7, 32'hBBBB); tick;
    wb_we = 1'b0;
    chk("newest_rs0", ex_d0, 32'hBBBB);
    chk("newest_rs1", ex_d1, 32'hBBBB);
    tick;

    // Backpressure: three back-to-back instructions, wb x3 mid-stall.
    ex_ready = 1'b0;
    issue(5'd1, 5'd3, 5'd11, 32'h200, 32'h11); tick;
    issue(5'd2, 5'd3, 5'd12, 32'h204, 32'h12); tick;
    issue(5'd3, 5'd4, 5'd13, 32'h208, 32'h13); settle;
    chk("stall_id_ready_full", {31'b0, id_ready}, 32'd0);
    tick;
    chk("stall_ex_rs1_pre", ex_d1, 32'hA000_0003);
    wb(5'd3, 32'h55); tick;
    wb_we = 1'b0; settle;
    chk("stall_ex_rs1_snoop", ex_d1, 32'h55);
    chk("stall_ex_rs0_stable", ex_d0, 32'hA000_0001);
    chk("stall_ex_pc_stable", ex_pc, 32'h200);
    chk("stall_ex_valid", {31'b0, ex_valid}, 32'd1);
    chk("stall_id_ready_held", {31'b0, id_ready}, 32'd0);
    tick;
    ex_ready = 1'b1; settle;
    chk("drain_id_ready", {31'b0, id_ready}, 32'd1);
    chk("drain0_pc", ex_pc, 32'h200);
    tick;
    id_valid = 1'b0;
    chk("drain1_pc", ex_pc, 32'h204);
    chk("drain1_rs0", ex_d0, 32'hA000_0002);
    chk("drain1_rs1", ex_d1, 32'h55);
    tick;
    chk("drain2_pc", ex_pc, 32'h208);
    chk("drain2_rs0", ex_d0, 32'h55);
    chk("drain2_rs1", ex_d1, 32'hA000_0004);
    tick;
    chk("drain_done_valid", {31'b0, ex_valid}, 32'd0);

    // Writes to x0 are never forwarded.
    issue(5'd0, 5'd0, 5'd3, 32'h300, 32'h3); wb(5'd0, 32'hFFFF); tick;
    id_valid = 1'b0; tick;
    wb_we = 1'b0;
    chk("x0_valid", {31'b0, ex_valid}, 32'd1);
    chk("x0_rs0", ex_d0, 32'h0);
    chk("x0_rs1", ex_d1, 32'h0);
    tick;

    // Flush with both slots full.
    ex_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd4, 32'h400, 32'h4); tick;
    issue(5'd2, 5'd1, 5'd5, 32'h404, 32'h5); tick;
    id_valid = 1'b0;
    chk("flush_pre_valid", {31'b0, ex_valid}, 32'd1);
    flush = 1'b1; settle;
    chk("flush_id_ready", {31'b0, id_ready}, 32'd0);
    tick;
    flush = 1'b0;
    chk("flush_ex_valid", {31'b0, ex_valid}, 32'd0);
    ex_ready = 1'b1; tick;
    chk("flush_s1_cleared", {31'b0, ex_valid}, 32'd0);

    // Reset in the middle of a stall.
    ex_ready = 1'b0;
    issue(5'd1, 5'd2, 5'd6, 32'h500, 32'h6); tick;
    issue(5'd2, 5'd1, 5'd7, 32'h504, 32'h7); tick;
    id_valid = 1'b0;
    rst = 1'b1; tick;
    rst = 1'b0; settle;
    chk("rst_mid_ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_mid_ex_pc", ex_pc, 32'h0);
    chk("rst_mid_id_ready", {31'b0, id_ready}, 32'd1);
    tick;
    chk("rst_mid_s1_cleared", {31'b0, ex_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
